// File: rtl/imm_pack.sv
// Packs a signed immediate into the RV32I I/S/B/J bit positions of an instruction template.
// Two-stage valid/ready pipeline with range/alignment flags and a saturating error counter.
module imm_pack #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           immsrc,
    input  logic [31:0]          imm,
    input  logic [31:0]          base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err_range,
    output logic                 err_align,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    logic        s1_valid;
    logic [1:0]  s1_immsrc;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    logic        s1_load;
    logic        s2_load;
    logic [31:0] pk_instr;
    logic        range_bad;
    logic        align_bad;

    // Handshake: a transfer happens on a rising edge where valid && ready; a producer
    // holds its word stable while valid && !ready. Stage 2 is the output register, so
    // in_ready depends on out_ready combinationally but nothing flows from in_valid to out_*.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        pk_instr  = s1_base;
        range_bad = 1'b0;
        align_bad = 1'b0;
        case (s1_immsrc)
            FMT_I: begin
                pk_instr  = {s1_imm[11:0], s1_base[19:0]};
                range_bad = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            FMT_S: begin
                pk_instr  = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
                range_bad = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            FMT_B: begin
                pk_instr  = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                             s1_imm[4:1], s1_imm[11], s1_base[6:0]};
                range_bad = !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
                align_bad = s1_imm[0];
            end
            FMT_J: begin
                pk_instr  = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                             s1_imm[19:12], s1_base[11:0]};
                range_bad = !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
                align_bad = s1_imm[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_immsrc <= 2'b00;
            s1_imm    <= 32'h0;
            s1_base   <= 32'h0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_immsrc <= immsrc;
                s1_imm    <= imm;
                s1_base   <= base;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            instr     <= 32'h0;
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr     <= pk_instr;
                err_range <= range_bad;
                err_align <= align_bad;
            end
        end
    end

    // Counted on the output transfer, so a stalled error word is counted exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_valid && out_ready && (err_range || err_align) && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed vector table, latency/backpressure/reset
// sequences, and randomized traffic against a bit-placement reference model.
module tb_imm_pack;

    localparam int EW = 68;  // {immsrc, imm, instr, err_range, err_align}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  immsrc = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] base = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr;
    logic        err_range;
    logic        err_align;
    logic [7:0]  err_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_instr;
    logic        sat_rng;
    logic        sat_aln;
    logic [1:0]  sat_count;

    int n_checks = 0;
    int n_pass = 0;
    int cnt_model = 0;
    int rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random
    logic [EW-1:0] exp_q[$];

    imm_pack #(.ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .err_range(err_range),
        .err_align(err_align), .err_count(err_count)
    );

    imm_pack #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
        .immsrc(immsrc), .imm(imm), .base(base), .out_valid(sat_out_valid),
        .out_ready(out_ready), .instr(sat_instr), .err_range(sat_rng),
        .err_align(sat_aln), .err_count(sat_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin : ready_driver
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: where immediate bit k lands in the instruction (-1 = not encoded).
    function automatic int dest(input logic [1:0] f, input int k);
        case (f)
            2'b00: return 20 + k;
            2'b01: return (k < 5) ? 7 + k : 25 + (k - 5);
            2'b10: begin
                if (k == 0) return -1;
                if (k < 5) return 8 + (k - 1);
                if (k < 11) return 25 + (k - 5);
                if (k == 11) return 7;
                return 31;
            end
            default: begin
                if (k == 0) return -1;
                if (k < 11) return 21 + (k - 1);
                if (k == 11) return 20;
                if (k < 20) return k;
                return 31;
            end
        endcase
    endfunction

    function automatic logic [33:0] model(input logic [1:0] f, input logic [31:0] v, input logic [31:0] b);
        int n;
        int sv;
        int p;
        logic [31:0] w;
        logic rng;
        logic aln;
        n = (f == 2'b10) ? 13 : (f == 2'b11) ? 21 : 12;
        w = b;
        for (int k = 0; k < n; k++) begin
            p = dest(f, k);
            if (p >= 0) w[p] = v[k];
        end
        sv = $signed(v);
        rng = (sv < -(1 << (n - 1))) || (sv > (1 << (n - 1)) - 1);
        aln = f[1] && v[0];
        return {w, rng, aln};
    endfunction

    // Decode-side extender, used for the round-trip property on error-free words.
    function automatic logic [31:0] extend(input logic [1:0] f, input logic [31:0] i);
        case (f)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // driver tasks
    task automatic send(input logic [1:0] f, input logic [31:0] v, input logic [31:0] b,
                        input logic [33:0] ex);
        int waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        immsrc = f;
        imm = v;
        base = b;
        #1;
        while (!in_ready && waits < 1000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({f, v, ex});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waits = 0;
        while (exp_q.size() != 0 && waits < 2000) begin
            @(posedge clk);
            waits++;
        end
        repeat (2) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Pipeline must be empty and ready forced high.
    task automatic send_latency(input string nm, input logic [1:0] f, input logic [31:0] v,
                                input logic [31:0] b, input logic [33:0] ex);
        send(f, v, b, ex);
        check({nm, "_not_yet_valid"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({nm, "_valid_at_2"}, out_valid, 1);
        check({nm, "_instr_at_2"}, instr, ex[33:2]);
        drain();
    endtask

    // scoreboard
    initial begin : monitor
        logic [EW-1:0] e;
        logic prev_stall;
        logic [31:0] prev_instr;
        logic [1:0] prev_flags;
        prev_stall = 1'b0;
        prev_instr = '0;
        prev_flags = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
                continue;
            end
            check("err_count", err_count, cnt_model);
            check("sat_count", sat_count, (cnt_model > 3) ? 3 : cnt_model);
            check("sat_instr", sat_instr, instr);
            if (prev_stall && out_valid) begin
                check("hold_instr", instr, prev_instr);
                check("hold_flags", {err_range, err_align}, prev_flags);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    check("instr", instr, e[33:2]);
                    check("flags", {err_range, err_align}, e[1:0]);
                    if (e[1:0] == 2'b00)
                        check("round_trip", extend(e[67:66], instr), e[65:34]);
                    else if (cnt_model < 255)
                        cnt_model++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = instr;
            prev_flags = {err_range, err_align};
        end
    end

    typedef struct {
        logic [1:0]  f;
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] ei;
        logic        er;
        logic        ea;
    } vec_t;

    vec_t vecs[14];

    initial begin : main
        int r;
        int sh;
        logic [1:0] f;
        logic [31:0] b;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'h00000008, 32'h00002023, 32'h00002423, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 32'h00000003, 32'h0000006F, 32'h0020006F, 1'b0, 1'b1};
        vecs[4]  = '{2'b11, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 32'h000007FF, 32'h00000093, 32'h7FF00093, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 32'h00000800, 32'h00000093, 32'h80000093, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 32'hFFFFF800, 32'h00002023, 32'h80002023, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 32'h00001000, 32'h00000063, 32'h80000063, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 32'h00000002, 32'h000000EF, 32'h002000EF, 1'b0, 1'b0};
        vecs[13] = '{2'b01, 32'h000007FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};

        // reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_err_count", err_count, 0);
        check("rst_sat_count", sat_count, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // directed: first five with exact latency, then the rest back-to-back
        for (int i = 0; i < 5; i++)
            send_latency($sformatf("vec%0d", i), vecs[i].f, vecs[i].v, vecs[i].b,
                         {vecs[i].ei, vecs[i].er, vecs[i].ea});
        check("err_count_after_j", err_count, 2);
        for (int i = 5; i < 14; i++)
            send(vecs[i].f, vecs[i].v, vecs[i].b, {vecs[i].ei, vecs[i].er, vecs[i].ea});
        drain();
        check("err_count_directed", err_count, 4);
        check("sat_count_saturated", sat_count, 3);

        // backpressure: four back-to-back words against a 3-cycle stall
        @(posedge clk);
        rdy_mode = 1;
        send(2'b00, 32'h00000001, 32'h00000013, model(2'b00, 32'h00000001, 32'h00000013));
        send(2'b01, 32'hFFFFFFF0, 32'h00002023, model(2'b01, 32'hFFFFFFF0, 32'h00002023));
        @(negedge clk);
        #1 check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_first_instr", instr, 32'h00100013);
        fork
            begin
                send(2'b10, 32'h00000010, 32'h00000063, model(2'b10, 32'h00000010, 32'h00000063));
                send(2'b11, 32'h00000800, 32'h0000006F, model(2'b11, 32'h00000800, 32'h0000006F));
            end
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // randomized traffic with random backpressure
        @(posedge clk);
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            f = 2'($urandom_range(0, 3));
            sh = $urandom_range(8, 31);
            r = $urandom;
            r = r >>> sh;
            if (f[1] && $urandom_range(0, 3) != 0) r[0] = 1'b0;
            b = $urandom;
            send(f, r, b, model(f, r, b));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();

        // reset with both stages full
        @(posedge clk);
        rdy_mode = 1;
        send(2'b10, 32'h00000FFF, 32'h00000063, model(2'b10, 32'h00000FFF, 32'h00000063));
        send(2'b00, 32'h00000900, 32'h00000013, model(2'b00, 32'h00000900, 32'h00000013));
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        cnt_model = 0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_flags", {err_range, err_align}, 0);
        rdy_mode = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        send_latency("post_rst", 2'b01, 32'h00000008, 32'h00002023, model(2'b01, 32'h00000008, 32'h00002023));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Encoder counterpart of the immediate extender: takes a signed 32-bit immediate, an immediate format (immsrc) and an instruction template, and packs the immediate into the RV32I bit positions for I/S/B/J formats.
- Checks range and alignment.
- Two-stage valid/ready pipeline with backpressure and a saturating error counter.
- Sits in the self-test/trace path. It generates instruction words for the fetch-side loader and is used as a round-trip checker against the decode-side extender.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- immsrc  input  2  format: 00=I, 01=S, 10=B, 11=J (same encoding as the extender).
- imm  input  32  signed immediate value (byte offset for B/J).
- base  input  32  instruction template; immediate bit positions are ignored and overwritten.
- out_valid  output  1  packed word valid.
- out_ready  input  1  consumer accepts word.
- instr  output  32  packed instruction word.
- err_range  output  1  imm outside field range (qualified by out_valid).
- err_align  output  1  B/J imm with imm[0]=1 (qualified by out_valid).
- err_count  output  ERR_CNT_W  count of emitted words with any error; saturates at all-ones.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, instr=0, err_range=0, err_align=0, err_count=0. in_ready=1 once reset deasserts.
- Handshakes:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - While out_valid&&!out_ready, instr/err_* are held stable.
- Pipeline:
  - Stage 1 registers immsrc/imm/base.
  - Stage 2 registers packed instr and flags; stage-2 outputs drive the output ports directly.
  - Latency: 2 cycles from input transfer to out_valid (no ready stall).
  - Throughput: 1 per cycle.
  - Stage advance: s2 loads when !s2_valid || out_ready. s1 loads when !s1_valid || s1 advances.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational from out_ready; no combinational path from in_valid to out_*.
  - Order preserved. No drop or duplication.
- Packing (computed from stage-1 contents):
  - I: instr[31:20]=imm[11:0]; instr[19:0]=base[19:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; instr[24:12], instr[6:0] from base.
  - B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]; instr[24:12], instr[6:0] from base.
  - J: instr[31]=imm[20], instr[19:12]=imm[19:12], instr[20]=imm[11], instr[30:21]=imm[10:1]; instr[11:0] from base.
- Range checks (signed):
  - I/S: -2048..2047.
  - B: -4096..4095.
  - J: -1048576..1048575.
  - Implementation: imm[31:N] must all equal imm[N-1], where N=12/12/13/21.
- err_align: set only for B/J when imm[0]=1; always 0 for I/S.
- Error words: on error the word is still emitted, truncated bits packed as above, with flags set. Both flags may be set together.
- err_count: increments by 1 on each output transfer where err_range||err_align, saturating at 2^ERR_CNT_W-1. It does not increment while a stalled error word is held.
- Round-trip property: for error-free words, the extender decoding instr[31:7] with the same immsrc returns imm exactly (B/J bit 0 = 0).
- Reset mid-operation: in-flight words are discarded and outputs return to reset values in the same cycle reset asserts.

Test Plan:
- I: immsrc=00, imm=0xFFFFFFFF, base=0x00000013 -> instr=0xFFF00013 two cycles after transfer, err_range=0, err_align=0.
- S: immsrc=01, imm=8, base=0x00002023 -> instr=0x00002423, no errors.
- B: immsrc=10, imm=0xFFFFFFFC, base=0x00000063 -> instr=0xFE000EE3, no errors. Round-trip through the extender gives 0xFFFFFFFC.
- J errors:
  - immsrc=11, imm=3 -> err_align=1, err_range=0, err_count becomes 1.
  - Then imm=0x00100000 -> err_range=1, err_count becomes 2.
  - Preload err_count near max with ERR_CNT_W=2 -> count stays at 3.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles.
  - in_ready drops once both stages are full.
  - instr is held stable while stalled.
  - All 4 words are delivered in order after out_ready=1, with no loss or duplicate.
- Reset asserted while both stages are valid -> out_valid=0, instr=0, err_count=0 immediately. First new input after release appears 2 cycles after transfer.
